// File: rtl/intc_pkg.sv
// Shared constants and helpers for the interrupt controller and its control unit.
`default_nettype none

package intc_pkg;

   localparam int             INT_W    = 8;
   localparam int             EXC_IDX  = 7;
   localparam logic [INT_W-1:0] EXC_MASK = 8'b1000_0000;
   localparam logic [INT_W-1:0] NO_INT   = 8'b0000_0000;

   // Binary index of a one-hot (or zero) vector; zero maps to 0.
   function automatic logic [2:0] lsb_index(input logic [INT_W-1:0] x);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = INT_W - 1; i >= 0; i--) begin
         if (x[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/intc_prio_lsb.sv
// Combinational lowest-set-bit isolator: the lowest index wins, zero in gives zero out.
`default_nettype none

module prio_lsb
   import intc_pkg::*;
(
   input  logic [INT_W-1:0] i_x,
   output logic [INT_W-1:0] o_lsb
);

   assign o_lsb = i_x & (~i_x + INT_W'(1));

endmodule

`default_nettype wire

// File: rtl/intc.sv
// Interrupt controller: synchronised edge-detected requests, pending and in-service
// registers, and the min_bit_s / min_bit_a pair consumed by the control unit.
`default_nettype none

module intc
   import intc_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int EXC_BIT     = EXC_IDX
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [INT_W-1:0] irq,
   input  logic [INT_W-1:0] irq_en,
   input  logic [INT_W-1:0] s_calli,
   input  logic [INT_W-1:0] s_reti,
   output logic [INT_W-1:0] min_bit_s,
   output logic [INT_W-1:0] min_bit_a,
   output logic [2:0]       int_vec,
   output logic [INT_W-1:0] pend,
   output logic [INT_W-1:0] isr
);

   localparam logic [INT_W-1:0] C_EXC_MASK = INT_W'(1) << EXC_BIT;

   logic [SYNC_STAGES-1:0][INT_W-1:0] r_sync;
   logic [INT_W-1:0]                  r_dly;
   logic [SYNC_STAGES:0]              r_arm;
   logic [INT_W-1:0]                  r_pend;
   logic [INT_W-1:0]                  r_isr;

   logic [INT_W-1:0] w_rise;
   logic [INT_W-1:0] w_c;
   logic [INT_W-1:0] w_r;
   logic [INT_W-1:0] w_isr_ret;
   logic             w_accept;
   logic [INT_W-1:0] w_take;
   logic [INT_W-1:0] w_sel;

   // Edge detection stays disarmed until the delay flop holds a real sample, so a
   // line held high through reset is not mistaken for a fresh rising edge.
   assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_dly & ~C_EXC_MASK
                      & {INT_W{r_arm[SYNC_STAGES]}};

   // Return is retired first so a same-cycle re-entry of that bit is allowed.
   assign w_isr_ret = r_isr & ~w_r;
   assign w_accept  = (w_c != NO_INT) && ((w_c & w_isr_ret) == NO_INT);
   assign w_take    = w_accept ? w_c : NO_INT;
   assign w_sel     = (r_pend & irq_en) | r_isr;

   prio_lsb u_lsb_call (.i_x(s_calli), .o_lsb(w_c));
   prio_lsb u_lsb_ret  (.i_x(s_reti),  .o_lsb(w_r));
   prio_lsb u_lsb_sel  (.i_x(w_sel),   .o_lsb(min_bit_s));
   prio_lsb u_lsb_act  (.i_x(r_isr),   .o_lsb(min_bit_a));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
         r_dly  <= '0;
         r_arm  <= '0;
         r_pend <= '0;
         r_isr  <= '0;
      end else begin
         r_sync[0] <= irq;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_dly  <= r_sync[SYNC_STAGES-1];
         r_arm  <= {r_arm[SYNC_STAGES-1:0], 1'b1};
         // A rise coinciding with acceptance re-arms pend so the event is kept.
         r_pend <= (r_pend & ~w_take) | w_rise;
         r_isr  <= w_isr_ret | w_take;
      end
   end

   assign int_vec = lsb_index(min_bit_s);
   assign pend    = r_pend;
   assign isr     = r_isr;

endmodule

`default_nettype wire
